moore_seq_fsm: RTL and testbench



---
 rtl/moore_seq_pkg.sv | 32 +++
 rtl/moore_seq_fsm_if.sv | 28 ++
 rtl/moore_seq_sat_cnt.sv | 18 +
 rtl/moore_seq_fsm.sv | 96 +++++++++
 tb/tb_moore_seq_fsm.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: shared defaults, mode constants and pattern helper for
// the moore_seq_fsm sequence detector. No ports (package).
package moore_seq_pkg;

    localparam int W_DEF = 2;
    localparam int DEPTH_DEF = 3;
    localparam logic [5:0] PATTERN_DEF = 6'b11_00_01;

    localparam int MODE_RESTART = 0;
    localparam int MODE_STICKY = 1;

    // Widest pattern / symbol the helper can slice.
    localparam int PAT_MAX = 256;
    localparam int SYM_MAX = 32;

    // Symbol k of a packed pattern of w-bit symbols; symbol 0 is the LSBs.
    function automatic logic [SYM_MAX-1:0] sym(
        input logic [PAT_MAX-1:0] pattern,
        input int k,
        input int w = W_DEF
    );
        logic [PAT_MAX-1:0] sh;
        logic [SYM_MAX-1:0] m;
        sh = pattern >> (k * w);
        m = '0;
        for (int i = 0; i < SYM_MAX; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return sh[SYM_MAX-1:0] & m;
    endfunction

endpackage

// File: rtl/moore_seq_fsm_if.sv
// moore_seq_fsm_if: bundle between switch bank and detector.
// master drives sw_in/ctrl_in/clr; slave (detector) drives state/out/match_cnt.
interface moore_seq_fsm_if
    import moore_seq_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int SW = $clog2(DEPTH + 1);

    logic [W-1:0]  sw_in;
    logic          ctrl_in;
    logic          clr;
    logic [SW-1:0] state;
    logic          out;
    logic [7:0]    match_cnt;

    modport master (
        output sw_in, ctrl_in, clr,
        input  state, out, match_cnt
    );

    modport slave (
        input  sw_in, ctrl_in, clr,
        output state, out, match_cnt
    );

endinterface

// File: rtl/moore_seq_sat_cnt.sv
// moore_seq_sat_cnt: 8-bit counter, +1 per inc cycle, sticks at 8'hFF.
// Ports: clk, reset (sync, active-high), inc, cnt[7:0].
module moore_seq_sat_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    output logic [7:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 8'h00;
        end else if (inc && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'h01;
        end
    end

endmodule

// File: rtl/moore_seq_fsm.sv
// moore_seq_fsm: enable-gated Moore detector for a DEPTH-symbol pattern.
// Ports: clk, reset (sync, active-high), bus (moore_seq_fsm_if.slave).
// Optional MOORE_SEQ_MATCH_CNT_EN adds the saturating match counter.
module moore_seq_fsm
    import moore_seq_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter logic [DEPTH*W-1:0] PATTERN = PATTERN_DEF,
    parameter int MODE = MODE_RESTART
) (
    input  logic clk,
    input  logic reset,
    moore_seq_fsm_if.slave bus
);

    localparam int SW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] S_ACC = SW'(DEPTH);
    localparam logic [SW-1:0] S_ONE = SW'(1);

    logic [W-1:0]  syms [DEPTH];
    logic [W-1:0]  cur_sym;
    logic [SW-1:0] st;
    logic [SW-1:0] nxt;
    logic          out_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_sym
        assign syms[g] = W'(sym(PAT_MAX'(PATTERN), g, W));
    end

    // Symbol expected in the current state (only meaningful below DEPTH).
    always_comb begin
        cur_sym = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (st == SW'(k)) cur_sym = syms[k];
        end
    end

    // Simple fallback: on a miss only a fresh symbol 0 is kept as progress.
    always_comb begin
        nxt = st;
        if (st < S_ACC) begin
            if (bus.sw_in == cur_sym) begin
                nxt = st + S_ONE;
            end else if (bus.sw_in == syms[0]) begin
                nxt = S_ONE;
            end else begin
                nxt = '0;
            end
        end else if (st == S_ACC) begin
            if (MODE == MODE_STICKY) begin
                nxt = S_ACC;
            end else if (bus.sw_in == syms[0]) begin
                nxt = S_ONE;
            end else begin
                nxt = '0;
            end
        end else begin
            nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= '0;
            out_q <= 1'b0;
        end else if (bus.clr) begin
            st    <= '0;
            out_q <= 1'b0;
        end else if (bus.ctrl_in) begin
            st    <= nxt;
            out_q <= (nxt == S_ACC);
        end
    end

    assign bus.state = st;
    assign bus.out   = out_q;

`ifdef MOORE_SEQ_MATCH_CNT_EN
    logic inc;

    // Sticky holds in MODE_STICKY re-enter DEPTH without a new match.
    assign inc = bus.ctrl_in && !bus.clr && (nxt == S_ACC)
               && ((st != S_ACC) || (MODE == MODE_RESTART));

    moore_seq_sat_cnt u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (inc),
        .cnt   (bus.match_cnt)
    );
`else
    assign bus.match_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_moore_seq_fsm.sv
// tb_moore_seq_fsm: directed + random checks of three moore_seq_fsm builds
// (DEPTH 3 restart, DEPTH 3 sticky, DEPTH 1 restart) against a model.
module tb_moore_seq_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    moore_seq_fsm_if #(.W(2), .DEPTH(3)) if0 ();
    moore_seq_fsm_if #(.W(2), .DEPTH(3)) if1 ();
    moore_seq_fsm_if #(.W(2), .DEPTH(1)) if2 ();

    moore_seq_fsm #(
        .W(2), .DEPTH(3), .PATTERN(6'b11_00_01), .MODE(0)
    ) u0 (.clk(clk), .reset(reset), .bus(if0));

    moore_seq_fsm #(
        .W(2), .DEPTH(3), .PATTERN(6'b11_00_01), .MODE(1)
    ) u1 (.clk(clk), .reset(reset), .bus(if1));

    moore_seq_fsm #(
        .W(2), .DEPTH(1), .PATTERN(2'b10), .MODE(0)
    ) u2 (.clk(clk), .reset(reset), .bus(if2));

    // Reference model: progress count and match count per instance.
    int dep [3] = '{3, 3, 1};
    int pat [3] = '{6'b11_00_01, 6'b11_00_01, 2'b10};
    int mod [3] = '{0, 1, 0};
    int p [3] = '{0, 0, 0};
    int c [3] = '{0, 0, 0};

`ifdef MOORE_SEQ_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    function automatic int symk(int pt, int k);
        return (pt >> (2 * k)) % 4;
    endfunction

    function automatic int next_p(int cur, int s, int d, int pt, int md);
        if (cur == d) begin
            if (md == 1) return d;
            return (s == symk(pt, 0)) ? 1 : 0;
        end
        if (s == symk(pt, cur)) return cur + 1;
        if (s == symk(pt, 0)) return 1;
        return 0;
    endfunction

    task automatic model_one(int i, int s, bit en, bit cl);
        int np;
        if (reset) begin
            p[i] = 0;
            c[i] = 0;
        end else if (cl) begin
            p[i] = 0;
        end else if (en) begin
            np = next_p(p[i], s, dep[i], pat[i], mod[i]);
            if (CNT_ON && np == dep[i] && (p[i] != dep[i] || mod[i] == 0))
                c[i] = (c[i] < 255) ? c[i] + 1 : 255;
            p[i] = np;
        end
    endtask

    task automatic check(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".st0"}, int'(if0.state), p[0]);
        check({tag, ".out0"}, int'(if0.out), int'(p[0] == 3));
        check({tag, ".cnt0"}, int'(if0.match_cnt), c[0]);
        check({tag, ".st1"}, int'(if1.state), p[1]);
        check({tag, ".out1"}, int'(if1.out), int'(p[1] == 3));
        check({tag, ".cnt1"}, int'(if1.match_cnt), c[1]);
        check({tag, ".st2"}, int'(if2.state), p[2]);
        check({tag, ".out2"}, int'(if2.out), int'(p[2] == 1));
        check({tag, ".cnt2"}, int'(if2.match_cnt), c[2]);
    endtask

    task automatic drive_a(int s, bit en, bit cl);
        if0.sw_in = 2'(s);
        if0.ctrl_in = en;
        if0.clr = cl;
        if1.sw_in = 2'(s);
        if1.ctrl_in = en;
        if1.clr = cl;
    endtask

    task automatic drive_b(int s, bit en, bit cl);
        if2.sw_in = 2'(s);
        if2.ctrl_in = en;
        if2.clr = cl;
    endtask

    // One clock: model samples the same inputs the DUTs see at the edge.
    task automatic tick(string tag);
        int s0;
        int s2;
        bit e0;
        bit e2;
        bit k0;
        bit k2;
        s0 = int'(if0.sw_in);
        e0 = if0.ctrl_in;
        k0 = if0.clr;
        s2 = int'(if2.sw_in);
        e2 = if2.ctrl_in;
        k2 = if2.clr;
        @(posedge clk);
        model_one(0, s0, e0, k0);
        model_one(1, s0, e0, k0);
        model_one(2, s2, e2, k2);
        #1;
        check_all(tag);
    endtask

    task automatic step_a(string tag, int s, bit en, bit cl);
        drive_a(s, en, cl);
        tick(tag);
    endtask

    initial begin
        drive_a(0, 1'b0, 1'b0);
        drive_b(0, 1'b0, 1'b0);
        reset = 1'b1;
        tick("rst0");
        tick("rst1");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) step_a("gate", 1, 1'b0, 1'b0);
        check("gate_st_const", int'(if0.state), 0);

        step_a("m1", 1, 1'b1, 1'b0);
        step_a("m2", 0, 1'b1, 1'b0);
        step_a("m3", 3, 1'b1, 1'b0);
        check("match_st3", int'(if0.state), 3);
        check("match_out", int'(if0.out), 1);
        check("match_cnt", int'(if0.match_cnt), CNT_ON ? 1 : 0);

        step_a("after", 1, 1'b1, 1'b0);
        check("restart_st", int'(if0.state), 1);
        check("sticky_st", int'(if1.state), 3);
        check("sticky_out", int'(if1.out), 1);
        check("sticky_cnt", int'(if1.match_cnt), CNT_ON ? 1 : 0);
        step_a("clr", 2, 1'b0, 1'b1);
        check("clr_out", int'(if1.out), 0);

        step_a("fb1", 1, 1'b1, 1'b0);
        step_a("fb2", 0, 1'b1, 1'b0);
        step_a("fb3", 1, 1'b1, 1'b0);
        check("fb_back1", int'(if0.state), 1);
        step_a("fb4", 0, 1'b1, 1'b0);
        step_a("fb5", 3, 1'b1, 1'b0);
        check("fb_done", int'(if0.out), 1);
        step_a("fbc", 0, 1'b0, 1'b1);
        step_a("fb6", 1, 1'b1, 1'b0);
        step_a("fb7", 2, 1'b1, 1'b0);
        check("fb_miss", int'(if0.state), 0);

        step_a("pr1", 1, 1'b1, 1'b0);
        step_a("pr2", 0, 1'b1, 1'b0);
        step_a("pr3", 3, 1'b1, 1'b1);
        check("prio_clr", int'(if0.state), 0);
        step_a("pr4", 1, 1'b1, 1'b0);
        reset = 1'b1;
        step_a("pr5", 0, 1'b1, 1'b1);
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            int s;
            s = ($urandom_range(0, 1) == 0) ? symk(pat[0], p[0] % 3)
                                            : int'($urandom_range(0, 3));
            reset = ($urandom_range(0, 99) == 0);
            drive_a(s, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            drive_b($urandom_range(0, 3), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 15) == 0);
            tick("rnd");
        end

        reset = 1'b1;
        drive_a(0, 1'b0, 1'b0);
        drive_b(0, 1'b0, 1'b0);
        tick("srst");
        reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive_b(2, 1'b1, 1'b0);
            tick("sat");
        end
        check("sat_final", int'(if2.match_cnt), CNT_ON ? 255 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
